i2c_regbank: RTL

//  Memory-mapped register bank between the SoC peripheral bus and the I2C mapping layer. Holds

---
 rtl/i2c_pkg.sv | 49 ++++
 rtl/i2c_status_sync.sv | 38 +++
 rtl/i2c_regbank.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared constants for the I2C register bank: register offsets, CONTROL/STATUS
// bit positions, sticky-flag indices and the synchronised-status bit layout.
package i2c_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned N_SYNC      = 9;
    localparam int unsigned N_STICKY    = 5;
    localparam int unsigned LIVE_W      = 15;

    localparam int unsigned OFF_CONTROL = 'h00;
    localparam int unsigned OFF_SADDR   = 'h04;
    localparam int unsigned OFF_RADDR   = 'h08;
    localparam int unsigned OFF_TXL     = 'h0C;
    localparam int unsigned OFF_TXH     = 'h10;
    localparam int unsigned OFF_RXL     = 'h14;
    localparam int unsigned OFF_RXH     = 'h18;
    localparam int unsigned OFF_STATUS  = 'h1C;
    localparam int unsigned OFF_IRQ_EN  = 'h20;

    localparam int unsigned CTRL_EN     = 20;
    localparam int unsigned CTRL_STRX   = 21;

    // Live STATUS bit positions in the I2C-domain status word
    localparam int unsigned ST_BUSY     = 0;
    localparam int unsigned ST_ERR      = 12;
    localparam int unsigned ST_TS       = 13;
    localparam int unsigned ST_RS       = 14;
    localparam int unsigned STICKY_LSB  = 16;

    // Index of each bit inside the packed 9-bit synchroniser vector
    localparam int unsigned SY_BUSY     = 0;
    localparam int unsigned SY_ERR      = 6;
    localparam int unsigned SY_TS       = 7;
    localparam int unsigned SY_RS       = 8;

    localparam int unsigned STK_TS      = 0;
    localparam int unsigned STK_RS      = 1;
    localparam int unsigned STK_ERR     = 2;
    localparam int unsigned STK_WERR    = 3;
    localparam int unsigned STK_TMO     = 4;

    localparam logic [DATA_W-1:0] REG_RST = '0;

    // Spread the 9 synchronised bits back to their STATUS[14:0] positions
    function automatic logic [LIVE_W-1:0] unpack_status(input logic [N_SYNC-1:0] v);
        return {v[8:5], 3'b000, v[4:3], 3'b000, v[2:0]};
    endfunction

endpackage

// File: rtl/i2c_status_sync.sv
// Per-bit two-flop synchroniser for the I2C-domain status bits, with a
// single-cycle rising-edge pulse per bit (rise_c is combinational from flops).
module i2c_status_sync #(
    parameter int unsigned N = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] async_i,
    output logic [N-1:0] sync_o,
    output logic [N-1:0] rise_c
);

    logic [N-1:0] meta_q, meta_d;
    logic [N-1:0] sync_q, sync_d;
    logic [N-1:0] prev_q, prev_d;

    always_comb begin
        meta_d = async_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_o = sync_q;
    assign rise_c = sync_q & ~prev_q;

endmodule

// File: rtl/i2c_regbank.sv
// CPU-visible register bank for the I2C mapping layer. Optional STRX watchdog
// is built when I2C_TIMEOUT_EN is defined.
module i2c_regbank
    import i2c_pkg::*;
#(
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned TIMEOUT_CYC = 65536
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_sel,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata,
    output logic              o_ready,
    output logic              o_irq,
    output logic [31:0]       wo_i2c_control_reg,
    output logic [31:0]       wo_i2c_saddr_reg,
    output logic [31:0]       wo_i2c_raddr_reg,
    output logic [31:0]       wo_i2c_TXDATA_l_reg,
    output logic [31:0]       wo_i2c_TXDATA_h_reg,
    input  logic [31:0]       ro_i2c_RXDATA_l_reg,
    input  logic [31:0]       ro_i2c_RXDATA_h_reg,
    input  logic [31:0]       ro_i2c_status_reg
);

    localparam int unsigned TMO_W = 32;

    logic [ADDR_W-1:0]   addr_w;
    logic                acc, wr, rd, busy, any_rise, tmo_hit, werr_set;
    logic [N_SYNC-1:0]   st_async, st_sync, st_rise;
    logic [LIVE_W-1:0]   status_live;
    logic [31:0]         read_mux;
    logic [N_STICKY-1:0] sticky_set, sticky_clr, irq_mask;

    logic [31:0] control_q, control_d, saddr_q, saddr_d, raddr_q, raddr_d;
    logic [31:0] txl_q, txl_d, txh_q, txh_d, rxl_q, rxl_d, rxh_q, rxh_d;
    logic [31:0] rdata_q, rdata_d;
    logic [N_STICKY-1:0] sticky_q, sticky_d, irq_en_q, irq_en_d;
    logic ready_q, ready_d, irq_q, irq_d;

    logic unused_ok;
    assign unused_ok = ^{i_addr[1:0], ro_i2c_status_reg[31:15],
                         ro_i2c_status_reg[10:8], ro_i2c_status_reg[5:3]};

    assign st_async = {ro_i2c_status_reg[14:11], ro_i2c_status_reg[7:6],
                       ro_i2c_status_reg[2:0]};

    i2c_status_sync #(.N(N_SYNC)) u_status_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (st_async),
        .sync_o  (st_sync),
        .rise_c  (st_rise)
    );

    assign status_live = unpack_status(st_sync);
    assign busy        = st_sync[SY_BUSY];
    assign any_rise    = st_rise[SY_TS] | st_rise[SY_RS] | st_rise[SY_ERR];
    assign addr_w      = {i_addr[ADDR_W-1:2], 2'b00};
    assign acc         = i_sel & ~ready_q;
    assign wr          = acc & i_we;
    assign rd          = acc & ~i_we;

`ifdef I2C_TIMEOUT_EN
    // Watchdog: counts while STRX is pending, cleared whenever STRX drops
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        tmo_cnt_d = '0;
        tmo_hit   = 1'b0;
        if (control_q[CTRL_STRX]) begin
            if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) tmo_hit = 1'b1;
            else tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_cnt_q <= '0;
        else        tmo_cnt_q <= tmo_cnt_d;
    end

    assign irq_mask = 5'h1F;
`else
    localparam int unsigned TMO_UNUSED = TIMEOUT_CYC;
    assign tmo_hit  = 1'b0;
    assign irq_mask = 5'h0F;
`endif

    always_comb begin
        read_mux = '0;
        case (addr_w)
            ADDR_W'(OFF_CONTROL): read_mux = control_q;
            ADDR_W'(OFF_SADDR):   read_mux = saddr_q;
            ADDR_W'(OFF_RADDR):   read_mux = raddr_q;
            ADDR_W'(OFF_TXL):     read_mux = txl_q;
            ADDR_W'(OFF_TXH):     read_mux = txh_q;
            ADDR_W'(OFF_RXL):     read_mux = rxl_q;
            ADDR_W'(OFF_RXH):     read_mux = rxh_q;
            ADDR_W'(OFF_STATUS):  read_mux = {11'b0, sticky_q, 1'b0, status_live};
            ADDR_W'(OFF_IRQ_EN):  read_mux = {27'b0, irq_en_q};
            default:              read_mux = '0;
        endcase
    end

    always_comb begin
        control_d  = control_q;
        saddr_d    = saddr_q;
        raddr_d    = raddr_q;
        txl_d      = txl_q;
        txh_d      = txh_q;
        rxl_d      = rxl_q;
        rxh_d      = rxh_q;
        irq_en_d   = irq_en_q;
        sticky_clr = '0;
        werr_set   = 1'b0;
        ready_d    = acc;
        rdata_d    = rd ? read_mux : '0;

        if (any_rise || tmo_hit) control_d[CTRL_STRX] = 1'b0;
        if (st_rise[SY_RS]) begin
            rxl_d = ro_i2c_RXDATA_l_reg;
            rxh_d = ro_i2c_RXDATA_h_reg;
        end

        // CPU writes last so a CONTROL write overrides the STRX auto-clear
        if (wr) begin
            case (addr_w)
                ADDR_W'(OFF_CONTROL): control_d = i_wdata;
                ADDR_W'(OFF_SADDR):   if (busy) werr_set = 1'b1; else saddr_d = i_wdata;
                ADDR_W'(OFF_RADDR):   if (busy) werr_set = 1'b1; else raddr_d = i_wdata;
                ADDR_W'(OFF_TXL):     if (busy) werr_set = 1'b1; else txl_d = i_wdata;
                ADDR_W'(OFF_TXH):     if (busy) werr_set = 1'b1; else txh_d = i_wdata;
                ADDR_W'(OFF_STATUS):  sticky_clr = i_wdata[STICKY_LSB +: N_STICKY];
                ADDR_W'(OFF_IRQ_EN):  irq_en_d = i_wdata[N_STICKY-1:0];
                default:              ;
            endcase
        end

        sticky_set = {tmo_hit, werr_set, st_rise[SY_ERR], st_rise[SY_RS], st_rise[SY_TS]};
        sticky_d   = (sticky_q & ~sticky_clr) | sticky_set;
        irq_d      = |(sticky_d & irq_en_d & irq_mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            control_q <= REG_RST;
            saddr_q   <= REG_RST;
            raddr_q   <= REG_RST;
            txl_q     <= REG_RST;
            txh_q     <= REG_RST;
            rxl_q     <= REG_RST;
            rxh_q     <= REG_RST;
            rdata_q   <= REG_RST;
            sticky_q  <= '0;
            irq_en_q  <= '0;
            ready_q   <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            control_q <= control_d;
            saddr_q   <= saddr_d;
            raddr_q   <= raddr_d;
            txl_q     <= txl_d;
            txh_q     <= txh_d;
            rxl_q     <= rxl_d;
            rxh_q     <= rxh_d;
            rdata_q   <= rdata_d;
            sticky_q  <= sticky_d;
            irq_en_q  <= irq_en_d;
            ready_q   <= ready_d;
            irq_q     <= irq_d;
        end
    end

    assign o_rdata             = rdata_q;
    assign o_ready             = ready_q;
    assign o_irq               = irq_q;
    assign wo_i2c_control_reg  = control_q;
    assign wo_i2c_saddr_reg    = saddr_q;
    assign wo_i2c_raddr_reg    = raddr_q;
    assign wo_i2c_TXDATA_l_reg = txl_q;
    assign wo_i2c_TXDATA_h_reg = txh_q;

endmodule
